// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin / fixed-priority arbiter for NUM_CDB result buses.
// In: clk_in, rst_in (async low), fu_valid/rob_ix/value/dest per FU, flush_in.
// Out: fu_read_out pulse per FU, cdb_valid/rob_ix/value/dest/src per bus.
module cdb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int NUM_CDB  = 1,
  parameter int DATA_W   = 32,
  parameter int ROB_IX_W = 3,
  parameter int DEST_W   = 5,
  parameter int RR_MODE  = 1
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [NUM_FU-1:0]                         fu_valid_in,
  input  logic [NUM_FU-1:0][ROB_IX_W-1:0]           fu_rob_ix_in,
  input  logic [NUM_FU-1:0][DATA_W-1:0]             fu_value_in,
  input  logic [NUM_FU-1:0][DEST_W-1:0]             fu_dest_in,
  input  logic                                      flush_in,
  output logic [NUM_FU-1:0]                         fu_read_out,
  output logic [NUM_CDB-1:0]                        cdb_valid_out,
  output logic [NUM_CDB-1:0][ROB_IX_W-1:0]          cdb_rob_ix_out,
  output logic [NUM_CDB-1:0][DATA_W-1:0]            cdb_value_out,
  output logic [NUM_CDB-1:0][DEST_W-1:0]            cdb_dest_out,
  output logic [NUM_CDB-1:0][$clog2(NUM_FU)-1:0]    cdb_src_out
);

  localparam int SRC_W = $clog2(NUM_FU);

  logic sync_q1;
  logic sync_q2;

  // Reset asserts at once, releases two edges later.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= 1'b1;
      sync_q2 <= sync_q1;
    end
  end

  logic [SRC_W-1:0]                  ptr_q;
  logic [SRC_W-1:0]                  ptr_d;
  logic [NUM_FU-1:0]                 elig;
  logic [NUM_FU-1:0]                 grant;
  logic                              arb_en;
  logic [NUM_CDB-1:0]                win_vld;
  logic [NUM_CDB-1:0][SRC_W-1:0]     win_src;
  logic [NUM_CDB-1:0][ROB_IX_W-1:0]  win_rob;
  logic [NUM_CDB-1:0][DATA_W-1:0]    win_val;
  logic [NUM_CDB-1:0][DEST_W-1:0]    win_dst;

  assign arb_en = sync_q2 & ~flush_in;

  // An FU whose read pulse is out still shows valid with stale data.
  assign elig = fu_valid_in & ~fu_read_out;

  always_comb begin : alloc
    int cnt;
    int idx;
    int last;
    cnt     = 0;
    idx     = 0;
    last    = 0;
    grant   = '0;
    win_vld = '0;
    win_src = '0;
    win_rob = '0;
    win_val = '0;
    win_dst = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (RR_MODE != 0) idx = (int'(ptr_q) + k) % NUM_FU;
      else              idx = k;
      if (arb_en && elig[idx] && cnt < NUM_CDB) begin
        grant[idx]   = 1'b1;
        win_vld[cnt] = 1'b1;
        win_src[cnt] = SRC_W'(idx);
        win_rob[cnt] = fu_rob_ix_in[idx];
        win_val[cnt] = fu_value_in[idx];
        win_dst[cnt] = fu_dest_in[idx];
        last         = idx;
        cnt          = cnt + 1;
      end
    end
    ptr_d = ptr_q;
    if (RR_MODE != 0 && cnt > 0)
      ptr_d = SRC_W'((last + 1) % NUM_FU);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_q          <= '0;
      fu_read_out    <= '0;
      cdb_valid_out  <= '0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_dest_out   <= '0;
      cdb_src_out    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      fu_read_out   <= grant;
      cdb_valid_out <= win_vld;
      // Idle buses keep old payload; consumers qualify with valid.
      for (int b = 0; b < NUM_CDB; b++) begin
        if (win_vld[b]) begin
          cdb_rob_ix_out[b] <= win_rob[b];
          cdb_value_out[b]  <= win_val[b];
          cdb_dest_out[b]   <= win_dst[b];
          cdb_src_out[b]    <= win_src[b];
        end
      end
    end
  end

endmodule
